// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM arbiter: FSM states, bus widths
// and the active-low strobe set driven in each phase.
package psram_pkg;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 16;
    localparam int SAMPLE_W = 12;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } psram_state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic adv_n;
    } psram_strobes_t;

    localparam psram_strobes_t STROBES_IDLE = '{default: STROBE_OFF};

    // Strobe pattern that belongs to a given phase of an access.
    function automatic psram_strobes_t strobes_for(input psram_state_e st, input logic is_wr);
        psram_strobes_t s;
        s = STROBES_IDLE;
        case (st)
            ST_SETUP: begin
                s.ce_n  = STROBE_ON;
                s.adv_n = STROBE_ON;
                s.ub_n  = STROBE_ON;
                s.lb_n  = STROBE_ON;
            end
            ST_ACCESS: begin
                s.ce_n = STROBE_ON;
                s.ub_n = STROBE_ON;
                s.lb_n = STROBE_ON;
                if (is_wr) s.we_n = STROBE_ON;
                else       s.oe_n = STROBE_ON;
            end
            default: s = STROBES_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/psram_wait_timer.sv
// Loadable 4-bit down-counter timing the strobe-active (ACCESS) phase.
module psram_wait_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       expired_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 4'd0);

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates the record (write) and playback (read) paths onto one async PSRAM,
// sequencing SETUP / ACCESS / DONE and owning both sample pointers.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEPTH       = 23'h7FFFFF,
    parameter int                WAIT_CYCLES = 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_req_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    output logic                wr_ack_o,
    input  logic                rd_req_i,
    output logic [SAMPLE_W-1:0] rd_data_o,
    output logic                rd_valid_o,
    input  logic                clear_i,
    output logic [ADDR_W-1:0]   record_count_o,
    output logic                busy_o,
    output logic                full_o,
    output logic                overflow_o,
    inout  wire  [DATA_W-1:0]   ram_data_io,
    output logic [ADDR_W-1:0]   address_o,
    output logic                chip_enable_o,
    output logic                output_enable_o,
    output logic                write_enable_o,
    output logic                upper_byte_o,
    output logic                lower_byte_o,
    output logic                address_valid_o,
    output logic [1:0]          state_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    psram_state_e        state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] wdata_q, wdata_d;
    logic [SAMPLE_W-1:0] rdata_q, rdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_valid_q, rd_valid_d;
    logic                ovf_q, ovf_d;
    logic                last_wr_q, last_wr_d;
    logic                clr_pend_q, clr_pend_d;
    logic                drive_q, drive_d;
    psram_strobes_t      strobes_q;

    logic timer_load, timer_expired;
    logic wr_pend, rd_pend, grant_wr, grant_rd;
    logic full, read_empty;

    psram_wait_timer u_wait_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (WAIT_LOAD),
        .expired_o  (timer_expired)
    );

    // A request still high while its own ack pulses is the finished one, not a new one.
    assign wr_pend    = wr_req_i & ~wr_ack_q;
    assign rd_pend    = rd_req_i & ~rd_valid_q;
    assign grant_wr   = wr_pend & (~rd_pend | ~last_wr_q);
    assign grant_rd   = rd_pend & ~grant_wr;
    assign full       = (wr_ptr_q == DEPTH);
    assign read_empty = (rd_ptr_q == wr_ptr_q);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_ack_d   = 1'b0;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        last_wr_d  = last_wr_q;
        clr_pend_d = clr_pend_q;
        drive_d    = 1'b0;
        timer_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    ovf_d      = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (grant_wr) begin
                    last_wr_d = 1'b1;
                    if (full) begin
                        wr_ack_d = 1'b1;
                        ovf_d    = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        is_wr_d = 1'b1;
                        addr_d  = wr_ptr_q;
                        wdata_d = wr_data_i;
                        drive_d = 1'b1;
                    end
                end else if (grant_rd) begin
                    last_wr_d = 1'b0;
                    if (read_empty && (wr_ptr_q == '0)) begin
                        rd_valid_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        // Caught up with the recording: loop playback from the start.
                        state_d  = ST_SETUP;
                        is_wr_d  = 1'b0;
                        rd_ptr_d = read_empty ? '0 : rd_ptr_q;
                        addr_d   = read_empty ? '0 : rd_ptr_q;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                timer_load = 1'b1;
                drive_d    = is_wr_q;
                clr_pend_d = clr_pend_q | clear_i;
            end
            ST_ACCESS: begin
                drive_d    = is_wr_q;
                clr_pend_d = clr_pend_q | clear_i;
                if (timer_expired) begin
                    state_d = ST_DONE;
                    drive_d = 1'b0;
                    if (is_wr_q) begin
                        wr_ack_d = 1'b1;
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end else begin
                        rd_valid_d = 1'b1;
                        rdata_d    = ram_data_io[SAMPLE_W-1:0];
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // Clear deferred from mid-access lands after that access's increment.
                if (clr_pend_q || clear_i) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    ovf_d      = 1'b0;
                    clr_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            last_wr_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            drive_q    <= 1'b0;
            strobes_q  <= STROBES_IDLE;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            last_wr_q  <= last_wr_d;
            clr_pend_q <= clr_pend_d;
            drive_q    <= drive_d;
            strobes_q  <= strobes_for(state_d, is_wr_d);
        end
    end

    assign ram_data_io = drive_q ? {{(DATA_W-SAMPLE_W){1'b0}}, wdata_q} : {DATA_W{1'bz}};

    assign address_o       = addr_q;
    assign chip_enable_o   = strobes_q.ce_n;
    assign output_enable_o = strobes_q.oe_n;
    assign write_enable_o  = strobes_q.we_n;
    assign upper_byte_o    = strobes_q.ub_n;
    assign lower_byte_o    = strobes_q.lb_n;
    assign address_valid_o = strobes_q.adv_n;

    assign wr_ack_o       = wr_ack_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rdata_q;
    assign record_count_o = wr_ptr_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign full_o         = full;
    assign overflow_o     = ovf_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: PSRAM bus model, table of single transactions,
// model-driven random traffic, and hand-written arbitration/clear/reset sequences.
module tb_psram_arbiter;

    localparam int          WAIT = 7;
    localparam logic [22:0] DEP  = 23'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, clear = 1'b0;
    logic [11:0] wr_data = 12'h0;
    logic        wr_ack, rd_valid, busy, full, ovf;
    logic [11:0] rd_data;
    logic [22:0] count, address;
    logic        ce_n, oe_n, we_n, ub_n, lb_n, adv_n;
    logic [1:0]  state;
    wire  [15:0] ram_data;
    wire  [5:0]  strb = {ce_n, oe_n, we_n, ub_n, lb_n, adv_n};

    psram_arbiter #(.DEPTH(DEP), .WAIT_CYCLES(WAIT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_req_i(wr_req), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .rd_req_i(rd_req), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .clear_i(clear), .record_count_o(count), .busy_o(busy),
        .full_o(full), .overflow_o(ovf), .ram_data_io(ram_data),
        .address_o(address), .chip_enable_o(ce_n), .output_enable_o(oe_n),
        .write_enable_o(we_n), .upper_byte_o(ub_n), .lower_byte_o(lb_n),
        .address_valid_o(adv_n), .state_o(state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- PSRAM model ----------------
    logic [15:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    assign ram_data = (!ce_n && !oe_n) ? mem[address[3:0]] : 16'hzzzz;
    always @(posedge clk) if (!ce_n && !we_n) mem[address[3:0]] = ram_data;

    // ---------------- scoreboard / monitor ----------------
    int n_tests = 0, n_fail = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int ce_cnt, we_cnt, oe_cnt, bus_err;
    logic [22:0] addr_seen;
    logic [11:0] mon_wdata = 12'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!ce_n) begin
            if (ce_cnt == 0) addr_seen = address;
            ce_cnt++;
        end
        if (!we_n) begin
            we_cnt++;
            if (ram_data !== {4'h0, mon_wdata}) bus_err++;
        end
        if (!oe_n) begin
            oe_cnt++;
            if (ram_data !== mem[address[3:0]]) bus_err++;
        end
        if (rd_valid && rst_n) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h with no read outstanding", rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("rd_data", {20'h0, rd_data}, {20'h0, exp_v});
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct packed {
        bit          is_rd;
        logic [11:0] data;
        int          exp_lat;
        bit          exp_ram;
        logic [22:0] exp_addr;
        logic [11:0] exp_rd;
        logic [22:0] exp_cnt;
        bit          exp_full;
        bit          exp_ovf;
    } vec_t;

    task automatic mon_reset();
        ce_cnt = 0; we_cnt = 0; oe_cnt = 0; bus_err = 0;
    endtask

    // Counts cycles after the sampling edge until the ack; -1 on timeout.
    task automatic wait_ack(input bit rd, output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = rd ? rd_valid : wr_ack;
        end
        if (!got) n = -1;
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        mon_reset();
        mon_wdata = v.data;
        if (v.is_rd) begin
            exp_q.push_back(v.exp_rd);
            rd_req = 1'b1;
        end else begin
            wr_data = v.data;
            wr_req  = 1'b1;
        end
        @(posedge clk);
        wait_ack(v.is_rd, lat);
        check(v.is_rd ? "rd_latency" : "wr_latency", lat, v.exp_lat);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        check("ce_cycles", ce_cnt, v.exp_ram ? 8 : 0);
        if (v.exp_ram) check("address", {9'h0, addr_seen}, {9'h0, v.exp_addr});
        check("we_cycles", we_cnt, (v.exp_ram && !v.is_rd) ? 7 : 0);
        check("oe_cycles", oe_cnt, (v.exp_ram && v.is_rd) ? 7 : 0);
        check("bus_value", bus_err, 0);
        check("record_count", {9'h0, count}, {9'h0, v.exp_cnt});
        check("full", full, v.exp_full);
        check("overflow", ovf, v.exp_ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // ---------------- reference model state ----------------
    int          m_wr, m_rd;
    bit          m_ovf;
    logic [11:0] m_mem [0:3];

    function automatic vec_t model_step(input bit is_rd, input logic [11:0] d);
        vec_t v;
        v = '0;
        v.is_rd = is_rd;
        v.data  = d;
        if (!is_rd) begin
            if (m_wr == int'(DEP)) begin
                v.exp_lat = 1;
                m_ovf = 1'b1;
            end else begin
                v.exp_lat = WAIT + 2;
                v.exp_ram = 1'b1;
                v.exp_addr = 23'(m_wr);
                m_mem[m_wr] = d;
                m_wr++;
            end
        end else if (m_rd == m_wr && m_wr == 0) begin
            v.exp_lat = 1;
            v.exp_rd  = 12'h0;
        end else begin
            if (m_rd == m_wr) m_rd = 0;
            v.exp_lat  = WAIT + 2;
            v.exp_ram  = 1'b1;
            v.exp_addr = 23'(m_rd);
            v.exp_rd   = m_mem[m_rd];
            m_rd++;
        end
        v.exp_cnt  = 23'(m_wr);
        v.exp_full = (m_wr == int'(DEP));
        v.exp_ovf  = m_ovf;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    vec_t vecs [11];
    int   ack_t [4];
    logic [3:0] ack_kind;
    int   nacks, t, lat, acks_seen;

    initial begin
        vecs[0]  = '{1'b1, 12'h000, 1, 1'b0, 23'd0, 12'h000, 23'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 12'hABC, 9, 1'b1, 23'd0, 12'h000, 23'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 12'h000, 9, 1'b1, 23'd0, 12'hABC, 23'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 12'h123, 9, 1'b1, 23'd1, 12'h000, 23'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 12'h000, 9, 1'b1, 23'd1, 12'h123, 23'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 12'h000, 9, 1'b1, 23'd0, 12'hABC, 23'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 12'h000, 9, 1'b1, 23'd1, 12'h123, 23'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 12'h000, 9, 1'b1, 23'd0, 12'hABC, 23'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 12'h456, 9, 1'b1, 23'd2, 12'h000, 23'd3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 12'h789, 9, 1'b1, 23'd3, 12'h000, 23'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 12'hFFF, 1, 1'b0, 23'd0, 12'h000, 23'd4, 1'b1, 1'b1};
        mon_reset();

        // Reset values, during and just after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {26'h0, strb}, 32'h3F);
        check("rst_bus_z", ram_data === 16'hzzzz, 1);
        check("rst_address", {9'h0, address}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_flags", {wr_ack, rd_valid, busy, full, ovf}, 0);
        check("rst_rd_data", {20'h0, rd_data}, 0);
        check("rst_count", {9'h0, count}, 0);
        check("rst_strobes_rel", {26'h0, strb}, 32'h3F);
        @(posedge clk);
        #1;

        // Both requesters held from IDLE: write, read, write, read, 10 cycles apart.
        mon_reset();
        wr_data = 12'hA01;
        mon_wdata = 12'hA01;
        exp_q.push_back(12'hA01);
        exp_q.push_back(12'hA02);
        wr_req = 1'b1;
        rd_req = 1'b1;
        @(posedge clk);
        nacks = 0;
        t = 0;
        ack_kind = 4'h0;
        while (nacks < 4 && t < 80) begin
            @(negedge clk);
            t++;
            if (wr_ack) begin
                ack_kind[nacks] = 1'b0;
                ack_t[nacks] = t;
                nacks++;
                wr_data = 12'hA02;
                mon_wdata = 12'hA02;
            end else if (rd_valid) begin
                ack_kind[nacks] = 1'b1;
                ack_t[nacks] = t;
                nacks++;
            end
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        check("tie_ack_count", nacks, 4);
        if (nacks == 4) begin
            check("tie_order", {28'h0, ack_kind}, 32'hA);
            check("tie_first_ack", ack_t[0], 9);
            for (int i = 1; i < 4; i++) check("tie_spacing", ack_t[i] - ack_t[i-1], 10);
        end
        check("tie_bus", bus_err, 0);
        check("tie_count", {9'h0, count}, 2);
        @(posedge clk);
        #1;

        // Directed table: empty read, write/read, looping playback, full, overflow.
        do_clear();
        for (int i = 0; i < 11; i++) run_txn(vecs[i]);
        do_clear();
        @(negedge clk);
        check("clr_count", {9'h0, count}, 0);
        check("clr_flags", {full, ovf}, 0);
        @(posedge clk);
        #1;

        // Random traffic against the pointer model.
        m_wr = 0; m_rd = 0; m_ovf = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 9) begin
                do_clear();
                m_wr = 0; m_rd = 0; m_ovf = 1'b0;
                @(negedge clk);
                check("rnd_clear_count", {9'h0, count}, 0);
                check("rnd_clear_ovf", ovf, 0);
                @(posedge clk);
                #1;
            end else begin
                run_txn(model_step(r >= 5, 12'($urandom_range(0, 4095))));
            end
        end

        // Clear with a simultaneous write in IDLE: clear first, write one cycle later.
        mon_reset();
        wr_data = 12'h5A5;
        mon_wdata = 12'h5A5;
        wr_req = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        wait_ack(1'b0, lat);
        check("clr_req_latency", lat, 10);
        @(posedge clk);
        #1 wr_req = 1'b0;
        @(negedge clk);
        check("clr_req_addr", {9'h0, addr_seen}, 0);
        check("clr_req_count", {9'h0, count}, 1);
        check("clr_req_ovf", ovf, 0);
        @(posedge clk);
        #1;

        // Clear during an access: the write completes, then both pointers are zero.
        mon_reset();
        wr_data = 12'h3C3;
        mon_wdata = 12'h3C3;
        wr_req = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        wait_ack(1'b0, lat);
        check("clr_mid_ack_seen", lat > 0, 1);
        @(posedge clk);
        #1 wr_req = 1'b0;
        @(negedge clk);
        check("clr_mid_addr", {9'h0, addr_seen}, 1);
        check("clr_mid_we", we_cnt, 7);
        check("clr_mid_count", {9'h0, count}, 0);
        @(posedge clk);
        #1;

        // Reset in the 3rd ACCESS cycle of a write.
        m_wr = 0; m_rd = 0; m_ovf = 1'b0;
        run_txn(model_step(1'b0, 12'h777));
        mon_reset();
        wr_data = 12'h888;
        mon_wdata = 12'h888;
        wr_req = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        check("mid_we_active", we_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {26'h0, strb}, 32'h3F);
        check("mid_rst_bus_z", ram_data === 16'hzzzz, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", {9'h0, count}, 0);
        acks_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (wr_ack) acks_seen++;
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wr_ack) acks_seen++;
        end
        check("mid_rst_no_ack", acks_seen, 0);
        check("mid_rel_busy", busy, 0);
        check("mid_rel_count", {9'h0, count}, 0);
        check("mid_rel_strobes", {26'h0, strb}, 32'h3F);
        check("rd_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
